// File: rtl/fpu_float_divide_pkg.sv
// fpu: shared FPU types, divider constants and operand decode helpers.
package fpu;
   typedef enum logic [1:0] {RNE, RTZ, DN, UP} fpu_round_mode_t;
   typedef enum logic [1:0] {IDLE, DIVIDE, DONE} fpu_div_state_t;
   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] mant;
   } fpu_float_t;
   typedef struct packed {
      logic guard;
      logic round;
      logic sticky;
   } fpu_guard_bits_t;
   typedef struct packed {
      logic nan;
      logic inf;
      logic zero;
   } fpu_class_t;
   typedef struct packed {
      logic            valid;
      logic            sign;
      logic            nan;
      logic            inf;
      logic            zero;
      logic [7:0]      exponent;
      logic [23:0]     mantissa;
      fpu_guard_bits_t guard;
      fpu_round_mode_t mode;
   } fpu_result_t;
   localparam int FPU_DIV_ITERATIONS = 26;
   localparam int FPU_DIV_EXP_BIAS = 127;
   // denormals (exp 0) classify as zero, i.e. flushed
   function automatic fpu_class_t fpu_decode_float(input fpu_float_t f);
      return '{nan: &f.exp && |f.mant, inf: &f.exp && ~|f.mant, zero: ~|f.exp};
   endfunction
   function automatic logic [23:0] fpu_float_get_mantissa(input fpu_float_t f);
      return {1'b1, f.mant};
   endfunction
endpackage

// File: rtl/fpu_float_divide_if.sv
// fpu_float_divide_if: operand/result valid-ready handshake bundle for the divider.
interface fpu_float_divide_if;
   import fpu::*;
   logic            in_valid;
   logic            in_ready;
   fpu_float_t      in_a;
   fpu_float_t      in_b;
   fpu_round_mode_t in_mode;
   logic            out_valid;
   logic            out_ready;
   fpu_result_t     out_result;
   modport master (output in_valid, in_a, in_b, in_mode, out_ready, input in_ready, out_valid, out_result);
   modport slave (input in_valid, in_a, in_b, in_mode, out_ready, output in_ready, out_valid, out_result);
endinterface

// File: rtl/fpu_float_divide_step.sv
// fpu_divide_step: one combinational restoring-division step (compare, subtract, shift).
module fpu_divide_step (
   input  logic [25:0] r,
   input  logic [23:0] mb,
   output logic [25:0] r_next,
   output logic        q
);
   assign q = r >= {2'b00, mb};
   assign r_next = (q ? r - {2'b00, mb} : r) << 1;
endmodule

// File: rtl/fpu_float_divide.sv
// fpu_float_divide: iterative binary32 divider producing an unrounded fpu_result_t.
// FPU_DIVIDE_RADIX4_EN: retire two quotient bits per cycle instead of one.
module fpu_float_divide
   import fpu::*;
(
   input logic clk,
   input logic rst_n,
   fpu_float_divide_if.slave bus
);
`ifdef FPU_DIVIDE_RADIX4_EN
   localparam int STEPS = 2;
`else
   localparam int STEPS = 1;
`endif
   localparam logic [4:0] LAST = 5'(FPU_DIV_ITERATIONS / STEPS - 1);
   fpu_div_state_t state, state_nx;
   fpu_class_t ca, cb, cls_in, cls_q;
   fpu_round_mode_t mode_q;
   fpu_result_t res;
   logic sign_q, nan_in, pre, special_q, ovf, unf, inf, zero;
   logic signed [9:0] e_nx, e_q;
   logic [23:0] ma, mb, mb_q;
   logic [25:0] r_q, q_q, q_nx;
   logic [4:0] cnt_q;
   logic [25:0] r_s [STEPS+1];
   logic [STEPS-1:0] q_s;
   assign ca = fpu_decode_float(bus.in_a);
   assign cb = fpu_decode_float(bus.in_b);
   assign ma = fpu_float_get_mantissa(bus.in_a);
   assign mb = fpu_float_get_mantissa(bus.in_b);
   assign nan_in = ca.nan | cb.nan | (ca.zero & cb.zero) | (ca.inf & cb.inf);
   assign cls_in = '{nan: nan_in, inf: !nan_in && (ca.inf || cb.zero),
                     zero: !nan_in && !(ca.inf || cb.zero) && (ca.zero || cb.inf)};
   // pre-normalise so the first quotient bit is always 1
   assign pre = ma < mb;
   assign e_nx = 10'(bus.in_a.exp) - 10'(bus.in_b.exp) + 10'(FPU_DIV_EXP_BIAS) - 10'(pre);
   assign r_s[0] = r_q;
   for (genvar i = 0; i < STEPS; i++) begin : g_step
      fpu_divide_step u_step (.r(r_s[i]), .mb(mb_q), .r_next(r_s[i+1]), .q(q_s[STEPS-1-i]));
   end
   assign q_nx = {q_q[25-STEPS:0], q_s};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb
      state_nx = state == IDLE ? (bus.in_valid ? (|cls_in ? DONE : DIVIDE) : IDLE)
               : state == DIVIDE ? (cnt_q == LAST ? DONE : DIVIDE)
               : bus.out_ready ? IDLE : DONE;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sign_q <= 1'b0;
         cls_q <= '0;
         mode_q <= RNE;
         e_q <= '0;
         mb_q <= '0;
         r_q <= '0;
         q_q <= '0;
         cnt_q <= '0;
      end else if (state == IDLE && bus.in_valid) begin
         sign_q <= bus.in_a.sign ^ bus.in_b.sign;
         cls_q <= cls_in;
         mode_q <= bus.in_mode;
         e_q <= e_nx;
         mb_q <= mb;
         r_q <= pre ? {1'b0, ma, 1'b0} : {2'b00, ma};
         q_q <= '0;
         cnt_q <= '0;
      end else if (state == DIVIDE) begin
         r_q <= r_s[STEPS];
         q_q <= q_nx;
         cnt_q <= cnt_q + 5'd1;
      end
   assign special_q = |cls_q;
   assign bus.in_ready = state == IDLE;
   assign bus.out_valid = state == DONE;
   always_comb begin
      ovf = !special_q && e_q >= 10'sd255;
      unf = !special_q && e_q <= 10'sd0;
      inf = cls_q.inf | ovf;
      zero = cls_q.zero | unf;
      res.valid = 1'b1;
      res.sign = !cls_q.nan && sign_q;
      res.nan = cls_q.nan;
      res.inf = inf;
      res.zero = zero;
      res.exponent = (cls_q.nan || inf) ? 8'hFF : zero ? 8'h00 : e_q[7:0];
      res.mantissa = cls_q.nan ? 24'h800000 : (inf || zero) ? 24'h0 : q_q[25:2];
      res.guard = (cls_q.nan || inf || zero) ? 3'b000 : {q_q[1:0], |r_q};
      res.mode = mode_q;
      bus.out_result = state == DONE ? res : '0;
   end
endmodule
